counter_gate_ctrl: RTL and testbench
====================================

COUNTER_GATE_CTRL -- requirements
Module: counter_gate_ctrl

Interface
REQ-001 SHALL have parameter NDIGIT, default 4: number of BCD digits of the controlled counter.
REQ-002 SHALL have parameter GATE_CYCLES, default 1000: gate length in clk cycles, legal range 1..2^20.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 2: wait after gate closes, legal range 1..15.
REQ-004 Port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 Port rst, input, 1: reset, asynchronous assertion, active-low.
REQ-006 Port start, input, 1: request to begin a measurement; sampled only in IDLE.
REQ-007 Port abort, input, 1: terminate any measurement in progress.
REQ-008 Port cont, input, 1: continuous mode; re-arm automatically after each result.
REQ-009 Port cnt_bcd, input, NDIGIT*4: live value of the BCD counter; digit 0 in [3:0].
REQ-010 Port cnt_clr, output, 1: active-high synchronous clear to the BCD counter.
REQ-011 Port cnt_en, output, 1: count enable to the BCD counter.
REQ-012 Port result, output, NDIGIT*4: latched measurement.
REQ-013 Port overflow, output, 1: latched with result; 1 when the counter wrapped during the measurement.
REQ-014 Port done, output, 1: one-cycle pulse; result and overflow are valid from this cycle.
REQ-015 Port busy, output, 1: high in every state except IDLE.

Function
REQ-016 FSM states: IDLE, CLEAR, GATE, SETTLE, LATCH; all outputs are registered or decoded from state only.
REQ-017 IDLE -> CLEAR on start=1 and abort=0; otherwise stay in IDLE.
REQ-018 CLEAR lasts exactly 1 cycle with cnt_clr=1 and cnt_en=0, then goes to GATE.
REQ-019 GATE lasts exactly GATE_CYCLES cycles with cnt_en=1; first enabled cycle is 2 cycles after the start sample edge.
REQ-020 SETTLE lasts exactly SETTLE_CYCLES cycles with cnt_en=0, then goes to LATCH.
REQ-021 LATCH lasts 1 cycle; on its closing edge: result<=cnt_bcd, overflow<=internal ovf flag, done<=1.
REQ-022 After LATCH: go to CLEAR if cont=1 and abort=0; otherwise go to IDLE.
REQ-023 done is high for exactly 1 cycle per completed measurement; otherwise 0.
REQ-024 Internal ovf flag cleared in CLEAR.
REQ-025 ovf flag set, sticky, in GATE or SETTLE when the most-significant digit of cnt_bcd goes from 9 (registered previous sample) to 0.
REQ-026 abort=1 in any non-IDLE state -> IDLE on the next edge.
REQ-027 On abort: cnt_en=0 from that edge; result and overflow unchanged; no done pulse.
REQ-028 abort has priority over start and over cont.
REQ-029 start while busy=1 is ignored; start is not queued.
REQ-030 Gate timer is a down-counter, width clog2(GATE_CYCLES+1); loaded with GATE_CYCLES-1 in CLEAR; GATE exits when it reads 0.

Reset
REQ-031 While rst=0: state=IDLE; cnt_clr, cnt_en, done, busy, overflow, ovf flag and gate timer are 0; result is all-zero.
REQ-032 Reset asserted mid-measurement SHALL immediately drop cnt_en, without waiting for a clock edge.
REQ-033 Reset release is synchronized to clk (two-flop deassertion synchronizer inside the block).

Structure
REQ-034 State encodings and the SETTLE_CYCLES default SHALL live in shared package counter_ctrl_pkg.
REQ-035 The gate timer SHALL be the sub-module gate_timer (load, decrement, zero flag); the FSM and latch registers stay in the top.

Verification
Common setup: 100 MHz clk, NDIGIT=4, and a real CounterBCD_Ndigit that counts every enabled clk.
REQ-036 Scenario GATE_CYCLES=100, single start pulse -> cnt_en high exactly 100 cycles; done once; result=16'h0100; overflow=0; busy returns to 0.
REQ-037 Scenario cont=1 held, GATE_CYCLES=37 -> three consecutive results all 16'h0037; done pulses spaced 37+1+2+1=41 cycles apart.
REQ-038 Scenario abort pulse at gate cycle 20 of 100, after a prior result 16'h0100 -> IDLE next cycle; no done; result stays 16'h0100.
REQ-039 Scenario GATE_CYCLES=10050 -> result=16'h0050; overflow=1; next run with GATE_CYCLES=100 gives overflow=0.
REQ-040 Scenario start pulses during GATE, and rst=0 asserted mid-GATE -> extra starts ignored; on reset cnt_en drops asynchronously and all outputs are 0 before the next clock edge.

Source files
------------

// File: rtl/counter_ctrl_pkg.sv
// Shared definitions for the BCD counter gate controller.
// Contents:
//   state_e               - controller FSM states
//   SETTLE_CYCLES_DEFAULT - default wait between gate close and result latch
//   SETTLE_W              - width of the settle down-counter (covers 1..15)
//   BCD_NINE              - largest legal BCD digit value
//   msd_wrapped()         - detects a 9 -> 0 transition of one BCD digit
package counter_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_GATE   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_LATCH  = 3'd4
  } state_e;

  localparam int SETTLE_CYCLES_DEFAULT = 2;
  localparam int SETTLE_W              = 4;
  localparam logic [3:0] BCD_NINE      = 4'd9;

  // A digit that was 9 on the previous sample and is 0 now has rolled over.
  function automatic logic msd_wrapped(input logic [3:0] prev, input logic [3:0] cur);
    return (prev == BCD_NINE) && (cur == 4'd0);
  endfunction

endpackage

// File: rtl/counter_gate_ctrl_gate_timer.sv
// gate_timer: loadable down-counter that times the counting gate.
// Ports:
//   clk_i      - clock, rising edge
//   rst_ni     - asynchronous active-low reset (already synchronized upstream)
//   load_i     - load load_val_i on the next edge (wins over dec_i)
//   load_val_i - value to load
//   dec_i      - decrement by one on the next edge; holds at zero
//   zero_o     - high while the counter reads zero
module gate_timer #(
  parameter int W = 10
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/counter_gate_ctrl.sv
// counter_gate_ctrl: sequences clear / gate / settle / latch for an external
// NDIGIT BCD counter and latches its value as a measurement result.
// Ports:
//   clk      - clock, all logic on the rising edge
//   rst      - active-low reset, asserts asynchronously, released synchronously
//   start    - begin a measurement (only looked at while idle)
//   abort    - drop any measurement in progress, highest priority
//   cont     - re-arm automatically after each result
//   cnt_bcd  - live counter value, digit 0 in [3:0]
//   cnt_clr  - synchronous clear to the counter
//   cnt_en   - count enable to the counter
//   result   - latched counter value
//   overflow - latched with result: counter wrapped during the measurement
//   done     - one-cycle pulse, result/overflow valid from this cycle
//   busy     - high whenever not idle
module counter_gate_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int NDIGIT        = 4,
  parameter int GATE_CYCLES   = 1000,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic                cont,
  input  logic [NDIGIT*4-1:0] cnt_bcd,
  output logic                cnt_clr,
  output logic                cnt_en,
  output logic [NDIGIT*4-1:0] result,
  output logic                overflow,
  output logic                done,
  output logic                busy
);

  localparam int TW = $clog2(GATE_CYCLES + 1);
  localparam logic [TW-1:0]       GATE_LOAD   = TW'(GATE_CYCLES - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);

  // Reset: assertion propagates through the async clear of both flops at
  // once, so every register below (and cnt_en) drops without a clock edge;
  // release reaches the logic two edges later.
  logic [1:0] rst_sync_q;
  logic       rst_n_int;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n_int = rst_sync_q[1];

  state_e state_q;
  state_e state_d;
  logic   gate_zero;

  gate_timer #(
    .W (TW)
  ) u_gate_timer (
    .clk_i      (clk),
    .rst_ni     (rst_n_int),
    .load_i     (state_q == ST_CLEAR),
    .load_val_i (GATE_LOAD),
    .dec_i      (state_q == ST_GATE),
    .zero_o     (gate_zero)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  logic [SETTLE_W-1:0] settle_q;
  logic [SETTLE_W-1:0] settle_d;

  // FSM next state; abort overrides every other transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_CLEAR;
      ST_CLEAR:  state_d = ST_GATE;
      ST_GATE:   if (gate_zero) state_d = ST_SETTLE;
      ST_SETTLE: if (settle_q == '0) state_d = ST_LATCH;
      ST_LATCH:  state_d = cont ? ST_CLEAR : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (abort) begin
      state_d = ST_IDLE;
    end
  end

  // FSM outputs, decoded from state only
  always_comb begin
    cnt_clr = (state_q == ST_CLEAR);
    cnt_en  = (state_q == ST_GATE);
    busy    = (state_q != ST_IDLE);
  end

  // Datapath: settle timer, wrap detection, result latch
  logic [3:0]          msd;
  logic [3:0]          msd_prev_q;
  logic [3:0]          msd_prev_d;
  logic                ovf_q;
  logic                ovf_d;
  logic [NDIGIT*4-1:0] result_q;
  logic [NDIGIT*4-1:0] result_d;
  logic                overflow_q;
  logic                overflow_d;
  logic                done_q;
  logic                done_d;
  logic                latch_fire;

  assign msd        = cnt_bcd[NDIGIT*4-1 -: 4];
  assign latch_fire = (state_q == ST_LATCH) && !abort;

  always_comb begin
    settle_d = settle_q;
    if (state_q == ST_GATE) begin
      settle_d = SETTLE_LOAD;
    end else if ((state_q == ST_SETTLE) && (settle_q != '0)) begin
      settle_d = settle_q - 4'd1;
    end

    // The counter is cleared on the CLEAR edge, so the previous-sample copy is
    // zeroed at the same time; otherwise a stale 9 from the last result would
    // look like a wrap on the first gate cycle.
    msd_prev_d = (state_q == ST_CLEAR) ? 4'd0 : msd;

    ovf_d = ovf_q;
    if (state_q == ST_CLEAR) begin
      ovf_d = 1'b0;
    end else if (((state_q == ST_GATE) || (state_q == ST_SETTLE)) &&
                 msd_wrapped(msd_prev_q, msd)) begin
      ovf_d = 1'b1;
    end

    result_d   = latch_fire ? cnt_bcd : result_q;
    overflow_d = latch_fire ? ovf_q   : overflow_q;
    done_d     = latch_fire;
  end

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      settle_q   <= '0;
      msd_prev_q <= '0;
      ovf_q      <= 1'b0;
      result_q   <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      settle_q   <= settle_d;
      msd_prev_q <= msd_prev_d;
      ovf_q      <= ovf_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  assign result   = result_q;
  assign overflow = overflow_q;
  assign done     = done_q;

endmodule

// File: tb/tb_counter_gate_ctrl.sv
// Bench for counter_gate_ctrl: three instances (gate 37, 100, 10050 cycles)
// each driving its own behavioural BCD counter. A cycle-level reference model
// tracks each measurement as "edges elapsed since the start was accepted".
`timescale 1ns/1ps
module tb_counter_gate_ctrl;

  localparam int NI = 3;
  localparam int SC = 2;
  localparam int G0 = 37;
  localparam int G1 = 100;
  localparam int G2 = 10050;

  function automatic int gate_of(input int i);
    return (i == 0) ? G0 : ((i == 1) ? G1 : G2);
  endfunction

  function automatic logic [15:0] bcd_inc(input logic [15:0] x);
    logic [15:0] y;
    logic        carry;
    y = x;
    carry = 1'b1;
    for (int d = 0; d < 4; d++) begin
      if (carry) begin
        if (y[d*4 +: 4] == 4'd9) begin
          y[d*4 +: 4] = 4'd0;
        end else begin
          y[d*4 +: 4] = y[d*4 +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    return y;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] y;
    int          r;
    r = v;
    y = '0;
    for (int d = 0; d < 4; d++) begin
      y[d*4 +: 4] = 4'(r % 10);
      r = r / 10;
    end
    return y;
  endfunction

  logic          clk;
  logic          rst;
  logic [NI-1:0] start_v;
  logic [NI-1:0] abort_v;
  logic [NI-1:0] cont_v;
  logic [NI-1:0] cnt_clr_v;
  logic [NI-1:0] cnt_en_v;
  logic [NI-1:0] overflow_v;
  logic [NI-1:0] done_v;
  logic [NI-1:0] busy_v;
  logic [15:0]   cnt_bcd_v [NI];
  logic [15:0]   result_v  [NI];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    logic [15:0] cnt_q;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt_q <= '0;
      end else if (cnt_clr_v[gi]) begin
        cnt_q <= '0;
      end else if (cnt_en_v[gi]) begin
        cnt_q <= bcd_inc(cnt_q);
      end
    end
    assign cnt_bcd_v[gi] = cnt_q;

    counter_gate_ctrl #(
      .NDIGIT        (4),
      .GATE_CYCLES   (gate_of(gi)),
      .SETTLE_CYCLES (SC)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start_v[gi]),
      .abort    (abort_v[gi]),
      .cont     (cont_v[gi]),
      .cnt_bcd  (cnt_bcd_v[gi]),
      .cnt_clr  (cnt_clr_v[gi]),
      .cnt_en   (cnt_en_v[gi]),
      .result   (result_v[gi]),
      .overflow (overflow_v[gi]),
      .done     (done_v[gi]),
      .busy     (busy_v[gi])
    );
  end

  int n_tests;
  int n_fail;
  int done_seen [NI];
  int en_seen   [NI];

  // Reference model
  int          m_k    [NI];   // 0 = idle, else edges since start accepted
  logic [15:0] m_res  [NI];
  logic        m_ovf  [NI];
  logic        m_done [NI];
  int          m_sync;

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] at %0t: got %h, want %h", name, idx, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_k[i]    = 0;
      m_res[i]  = '0;
      m_ovf[i]  = 1'b0;
      m_done[i] = 1'b0;
    end
    m_sync = 0;
  endtask

  task automatic model_edge();
    int g;
    if (!rst) begin
      model_reset();
      return;
    end
    if (m_sync < 2) begin
      m_sync++;
      return;
    end
    for (int i = 0; i < NI; i++) begin
      g = gate_of(i);
      m_done[i] = 1'b0;
      if (m_k[i] == 0) begin
        if (start_v[i] && !abort_v[i]) m_k[i] = 1;
      end else if (abort_v[i]) begin
        m_k[i] = 0;
      end else if (m_k[i] == g + SC + 2) begin
        m_res[i]  = to_bcd(g % 10000);
        m_ovf[i]  = (g >= 10000);
        m_done[i] = 1'b1;
        m_k[i]    = cont_v[i] ? 1 : 0;
      end else begin
        m_k[i]++;
      end
    end
  endtask

  task automatic check_outputs();
    int k;
    int g;
    for (int i = 0; i < NI; i++) begin
      k = m_k[i];
      g = gate_of(i);
      check("busy",     i, 32'(busy_v[i]),     32'(k != 0));
      check("cnt_clr",  i, 32'(cnt_clr_v[i]),  32'(k == 1));
      check("cnt_en",   i, 32'(cnt_en_v[i]),   32'((k >= 2) && (k <= g + 1)));
      check("done",     i, 32'(done_v[i]),     32'(m_done[i]));
      check("result",   i, 32'(result_v[i]),   32'(m_res[i]));
      check("overflow", i, 32'(overflow_v[i]), 32'(m_ovf[i]));
      if (done_v[i])   done_seen[i]++;
      if (cnt_en_v[i]) en_seen[i]++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  typedef struct {
    bit          start;
    bit          abort;
    bit          cont;
    int          cycles;
    bit          exp_busy;
    int          exp_dones;
    logic [15:0] exp_result;
  } vec_t;

  vec_t tbl [10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < NI; i++) begin
      done_seen[i] = 0;
      en_seen[i]   = 0;
    end
    start_v = '0;
    abort_v = '0;
    cont_v  = '0;
    rst     = 1'b1;
    model_reset();
    #1 rst = 1'b0;

    // Reset state
    repeat (3) tick();

    // Release with start already held on instance 1: two edges of sync first
    rst = 1'b1;
    start_v[1] = 1'b1;
    tick();
    check("sync_edge1_busy", 1, 32'(busy_v[1]), 32'd0);
    tick();
    check("sync_edge2_busy", 1, 32'(busy_v[1]), 32'd0);
    tick();
    check("sync_edge3_busy", 1, 32'(busy_v[1]), 32'd1);
    start_v[1] = 1'b0;

    // Single measurement, gate 100
    for (int c = 0; c < 300 && done_seen[1] == 0; c++) tick();
    check("g100_done_count", 1, 32'(done_seen[1]), 32'd1);
    check("g100_en_cycles",  1, 32'(en_seen[1]),   32'd100);
    check("g100_result",     1, 32'(result_v[1]),  32'h0100);
    check("g100_overflow",   1, 32'(overflow_v[1]), 32'd0);
    tick();
    check("g100_idle_busy",  1, 32'(busy_v[1]), 32'd0);
    check("g100_done_low",   1, 32'(done_v[1]), 32'd0);

    // Abort at gate cycle 20 after the prior 0100 result
    start_v[1] = 1'b1;
    tick();
    start_v[1] = 1'b0;
    repeat (20) tick();
    check("abort_pre_en", 1, 32'(cnt_en_v[1]), 32'd1);
    abort_v[1] = 1'b1;
    tick();
    abort_v[1] = 1'b0;
    check("abort_busy",   1, 32'(busy_v[1]),   32'd0);
    check("abort_cnt_en", 1, 32'(cnt_en_v[1]), 32'd0);
    repeat (150) tick();
    check("abort_no_done", 1, 32'(done_seen[1]), 32'd1);
    check("abort_result",  1, 32'(result_v[1]),  32'h0100);

    // Table-driven sequence on instance 0 (gate 37, settle 2: done 41 edges after start)
    tbl[0] = '{1'b1, 1'b0, 1'b0,  1, 1'b1, 0, 16'h0000};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 39, 1'b1, 0, 16'h0000};
    tbl[2] = '{1'b0, 1'b0, 1'b0,  2, 1'b0, 1, 16'h0037};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 41, 1'b1, 0, 16'h0037};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 82, 1'b1, 2, 16'h0037};
    tbl[5] = '{1'b0, 1'b1, 1'b1,  1, 1'b0, 0, 16'h0037};
    tbl[6] = '{1'b0, 1'b0, 1'b0,  5, 1'b0, 0, 16'h0037};
    tbl[7] = '{1'b1, 1'b1, 1'b0,  3, 1'b0, 0, 16'h0037};
    tbl[8] = '{1'b1, 1'b0, 1'b1, 41, 1'b1, 0, 16'h0037};
    tbl[9] = '{1'b0, 1'b0, 1'b0,  1, 1'b0, 1, 16'h0037};
    for (int r = 0; r < 10; r++) begin
      d0 = done_seen[0];
      for (int c = 0; c < tbl[r].cycles; c++) begin
        start_v[0] = (c == 0) ? tbl[r].start : 1'b0;
        abort_v[0] = (c == 0) ? tbl[r].abort : 1'b0;
        cont_v[0]  = tbl[r].cont;
        tick();
      end
      check($sformatf("tbl%0d_busy", r),   0, 32'(busy_v[0]), 32'(tbl[r].exp_busy));
      check($sformatf("tbl%0d_dones", r),  0, 32'(done_seen[0] - d0), 32'(tbl[r].exp_dones));
      check($sformatf("tbl%0d_result", r), 0, 32'(result_v[0]), 32'(tbl[r].exp_result));
    end
    start_v[0] = 1'b0;
    abort_v[0] = 1'b0;
    cont_v[0]  = 1'b0;

    // Overflow: gate 10050 wraps the 4-digit counter once
    start_v[2] = 1'b1;
    tick();
    start_v[2] = 1'b0;
    for (int c = 0; c < 10200 && done_seen[2] == 0; c++) tick();
    check("ovf_done_count", 2, 32'(done_seen[2]), 32'd1);
    check("ovf_en_cycles",  2, 32'(en_seen[2]),   32'd10050);
    check("ovf_result",     2, 32'(result_v[2]),  32'h0050);
    check("ovf_flag",       2, 32'(overflow_v[2]), 32'd1);
    check("no_ovf_g100",    1, 32'(overflow_v[1]), 32'd0);

    // Randomized traffic on all instances, scored by the model each cycle
    for (int c = 0; c < 2500; c++) begin
      for (int i = 0; i < NI; i++) begin
        start_v[i] = ($urandom_range(7) == 0);
        abort_v[i] = ($urandom_range(63) == 0);
        if ($urandom_range(31) == 0) cont_v[i] = ~cont_v[i];
      end
      tick();
    end
    start_v = '0;
    cont_v  = '0;
    abort_v = '1;
    tick();
    abort_v = '0;

    // Extra starts during GATE, then asynchronous reset mid-GATE
    start_v = 3'b011;
    tick();
    start_v = '0;
    repeat (5) tick();
    start_v = 3'b011;
    tick();
    start_v = '0;
    repeat (4) tick();
    check("pre_rst_en", 0, 32'(cnt_en_v[0]), 32'd1);
    check("pre_rst_en", 1, 32'(cnt_en_v[1]), 32'd1);
    #2 rst = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      check("async_cnt_en",   i, 32'(cnt_en_v[i]),   32'd0);
      check("async_cnt_clr",  i, 32'(cnt_clr_v[i]),  32'd0);
      check("async_busy",     i, 32'(busy_v[i]),     32'd0);
      check("async_done",     i, 32'(done_v[i]),     32'd0);
      check("async_result",   i, 32'(result_v[i]),   32'd0);
      check("async_overflow", i, 32'(overflow_v[i]), 32'd0);
    end
    repeat (2) tick();
    rst = 1'b1;
    repeat (4) tick();

    // Recovery: a clean measurement after reset
    d0 = done_seen[0];
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    for (int c = 0; c < 100 && done_seen[0] == d0; c++) tick();
    check("recover_done",   0, 32'(done_seen[0] - d0), 32'd1);
    check("recover_result", 0, 32'(result_v[0]), 32'h0037);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
